// File: rtl/comp_arbiter.sv
// rtl/comp_arbiter.sv - two-requester round-robin front end for a shared external comparator
module comp_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic             i_req0_eq,
    input  logic [1:0]       i_req0_mode,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic             i_req1_eq,
    input  logic [1:0]       i_req1_mode,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    output logic             o_cmp_eq,
    output logic [1:0]       o_cmp_mode,
    output logic [WIDTH-1:0] o_cmp_a,
    output logic [WIDTH-1:0] o_cmp_b,
    input  logic [31:0]      i_cmp_result,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [31:0]      o_rsp_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant;
    logic             any_valid;
    logic             handshake;
    logic             eq_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic             result_q;
    logic             cmp_result_unused;

    // Only bit 0 of the comparator result is meaningful; upper bits are dropped.
    assign cmp_result_unused = ^i_cmp_result[31:1];

    // Round-robin pick: on a tie the requester not served last wins; a lone requester always wins.
    always_comb begin
        any_valid = i_req0_valid | i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = i_req1_valid;
        end
    end

    // Readiness is offered only in IDLE, to the granted requester, and never while reset is held.
    always_comb begin
        o_req0_ready = i_rst_n && (state == IDLE) && any_valid && !grant;
        o_req1_ready = i_rst_n && (state == IDLE) && any_valid && grant;
        handshake    = (state == IDLE) && any_valid;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept, compare for one cycle, then hold the response until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = CMP;
            CMP:     state_next = RESP;
            RESP:    if (i_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the granted request's fields and advance the round-robin pointer on acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant <= 1'b1;
            eq_q       <= 1'b0;
            mode_q     <= 2'b00;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
        end else if (handshake) begin
            last_grant <= grant;
            id_q       <= grant;
            eq_q       <= grant ? i_req1_eq   : i_req0_eq;
            mode_q     <= grant ? i_req1_mode : i_req0_mode;
            a_q        <= grant ? i_req1_a    : i_req0_a;
            b_q        <= grant ? i_req1_b    : i_req0_b;
        end
    end

    // Sample the external comparator's verdict during the compare cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= 1'b0;
        end else if (state == CMP) begin
            result_q <= i_cmp_result[0];
        end
    end

    // Operand and response outputs come straight from registered fields.
    always_comb begin
        o_cmp_eq     = eq_q;
        o_cmp_mode   = mode_q;
        o_cmp_a      = a_q;
        o_cmp_b      = b_q;
        o_rsp_valid  = (state == RESP);
        o_rsp_id     = id_q;
        o_rsp_result = {31'b0, result_q};
    end

endmodule
